// File: rtl/helios_stream_dispatcher.sv
// helios_stream_dispatcher
// Shares one host byte link among NUM_CORES decoder cores. Each incoming frame
// goes to a free core in round-robin order, and results return to the host in
// input order. Each core holds at most one frame at a time.
// Build option: define HELIOS_DISPATCH_TAG_EN to give every input frame a
// one-byte header. That header is echoed in front of the matching result frame.
// Without the macro, frames are raw payload bytes only.
//
// state      | meaning
// IN_IDLE    | wait for a core with no outstanding frame, latch it as sel
// IN_HDR     | accept the header byte into tag_reg (tag build only)
// IN_PAYLOAD | pass FRAME_LEN bytes straight through to core sel
// OUT_IDLE   | wait for an entry in the order FIFO, pop it
// OUT_HDR    | present the echoed tag byte (tag build only)
// OUT_PAYLOAD| pass RESULT_LEN bytes straight through from core out_sel
module helios_stream_dispatcher #(
    parameter int NUM_CORES  = 2,
    parameter int FRAME_LEN  = 3,
    parameter int RESULT_LEN = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             input_data,
    input  logic                   input_valid,
    output logic                   input_ready,
    output logic [7:0]             output_data,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [8*NUM_CORES-1:0] core_input_data,
    output logic [NUM_CORES-1:0]   core_input_valid,
    input  logic [NUM_CORES-1:0]   core_input_ready,
    input  logic [8*NUM_CORES-1:0] core_output_data,
    input  logic [NUM_CORES-1:0]   core_output_valid,
    output logic [NUM_CORES-1:0]   core_output_ready
);

    localparam int IDX_W   = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int MAX_LEN = (FRAME_LEN > RESULT_LEN) ? FRAME_LEN : RESULT_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);
    localparam int OCC_W   = $clog2(NUM_CORES + 1);
`ifdef HELIOS_DISPATCH_TAG_EN
    localparam int ENT_W   = IDX_W + 8;
`else
    localparam int ENT_W   = IDX_W;
`endif
    localparam logic [CNT_W-1:0] FRAME_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] RESULT_LAST = CNT_W'(RESULT_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_CORES - 1);

    typedef enum logic [1:0] {IN_IDLE, IN_HDR, IN_PAYLOAD}    in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_HDR, OUT_PAYLOAD} out_state_t;

    in_state_t        in_state, in_state_nxt;
    out_state_t       out_state, out_state_nxt;
    logic [IDX_W-1:0] sel, rr_ptr, free_idx, out_sel;
    logic             free_any;
    logic [CNT_W-1:0] in_cnt, out_cnt;
    logic [NUM_CORES-1:0] outstanding;
    logic             in_fire, out_fire, in_last, out_last, push, pop;

    logic [ENT_W-1:0] fifo_mem [NUM_CORES];
    logic [ENT_W-1:0] fifo_in, fifo_head;
    logic [IDX_W-1:0] wr_ptr, rd_ptr;
    logic [OCC_W-1:0] fifo_cnt;

`ifdef HELIOS_DISPATCH_TAG_EN
    logic [7:0]       tag_reg, out_tag;
`endif

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign in_fire   = input_valid & input_ready;
    assign out_fire  = output_valid & output_ready;
    assign in_last   = (in_state == IN_PAYLOAD) && in_fire && (in_cnt == FRAME_LAST);
    assign out_last  = (out_state == OUT_PAYLOAD) && out_fire && (out_cnt == RESULT_LAST);
    assign push      = in_last;
    assign pop       = (out_state == OUT_IDLE) && (fifo_cnt != '0);
    assign fifo_head = fifo_mem[rd_ptr];
`ifdef HELIOS_DISPATCH_TAG_EN
    assign fifo_in   = {sel, tag_reg};
`else
    assign fifo_in   = sel;
`endif

    // Round-robin search: the last hit while scanning downward is the first free core at or after rr_ptr
    always_comb begin
        int c;
        free_any = 1'b0;
        free_idx = '0;
        c        = 0;
        for (int j = NUM_CORES - 1; j >= 0; j--) begin
            c = int'(rr_ptr) + j;
            if (c >= NUM_CORES) c = c - NUM_CORES;
            if (!outstanding[c]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(c);
            end
        end
    end

    // Input FSM next state and the payload pass-through to core sel
    always_comb begin
        in_state_nxt     = in_state;
        input_ready      = 1'b0;
        core_input_valid = '0;
        core_input_data  = '0;
        case (in_state)
            IN_IDLE: begin
`ifdef HELIOS_DISPATCH_TAG_EN
                if (free_any) in_state_nxt = IN_HDR;
`else
                if (free_any) in_state_nxt = IN_PAYLOAD;
`endif
            end
`ifdef HELIOS_DISPATCH_TAG_EN
            IN_HDR: begin
                input_ready = 1'b1;
                if (input_valid) in_state_nxt = IN_PAYLOAD;
            end
`endif
            IN_PAYLOAD: begin
                core_input_data[{sel, 3'b000} +: 8] = input_data;
                core_input_valid[sel]               = input_valid;
                input_ready                         = core_input_ready[sel];
                if (input_valid && core_input_ready[sel] && (in_cnt == FRAME_LAST))
                    in_state_nxt = IN_IDLE;
            end
            default: in_state_nxt = IN_IDLE;
        endcase
    end

    // Input FSM registers: core selection, payload count, round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state <= IN_IDLE;
            sel      <= '0;
            in_cnt   <= '0;
            rr_ptr   <= '0;
        end else begin
            in_state <= in_state_nxt;
            if (in_state == IN_IDLE && free_any) sel <= free_idx;
            if (in_state == IN_PAYLOAD && in_fire) begin
                if (in_cnt == FRAME_LAST) begin
                    in_cnt <= '0;
                    rr_ptr <= ptr_inc(sel);
                end else begin
                    in_cnt <= in_cnt + 1'b1;
                end
            end
        end
    end

`ifdef HELIOS_DISPATCH_TAG_EN
    // Capture the frame header as its tag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                tag_reg <= '0;
        else if (in_state == IN_HDR && input_valid) tag_reg <= input_data;
    end
`endif

    // A core is busy from its last payload byte in until its last result byte out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outstanding <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (in_last && sel == IDX_W'(i))
                    outstanding[i] <= 1'b1;
                else if (out_last && out_sel == IDX_W'(i))
                    outstanding[i] <= 1'b0;
            end
        end
    end

    // Order FIFO storage; holds at most one entry per core, so it never overflows
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= fifo_in;
    end

    // Order FIFO pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Output FSM next state and the result pass-through from core out_sel
    always_comb begin
        out_state_nxt     = out_state;
        output_valid      = 1'b0;
        output_data       = '0;
        core_output_ready = '0;
        case (out_state)
            OUT_IDLE: begin
`ifdef HELIOS_DISPATCH_TAG_EN
                if (fifo_cnt != '0) out_state_nxt = OUT_HDR;
`else
                if (fifo_cnt != '0) out_state_nxt = OUT_PAYLOAD;
`endif
            end
`ifdef HELIOS_DISPATCH_TAG_EN
            OUT_HDR: begin
                output_valid = 1'b1;
                output_data  = out_tag;
                if (output_ready) out_state_nxt = OUT_PAYLOAD;
            end
`endif
            OUT_PAYLOAD: begin
                output_data                = core_output_data[{out_sel, 3'b000} +: 8];
                output_valid               = core_output_valid[out_sel];
                core_output_ready[out_sel] = output_ready;
                if (core_output_valid[out_sel] && output_ready && (out_cnt == RESULT_LAST))
                    out_state_nxt = OUT_IDLE;
            end
            default: out_state_nxt = OUT_IDLE;
        endcase
    end

    // Output FSM registers: popped FIFO head and result byte count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_state <= OUT_IDLE;
            out_sel   <= '0;
            out_cnt   <= '0;
        end else begin
            out_state <= out_state_nxt;
            if (pop) out_sel <= fifo_head[ENT_W-1 -: IDX_W];
            if (out_state == OUT_PAYLOAD && out_fire)
                out_cnt <= (out_cnt == RESULT_LAST) ? '0 : out_cnt + 1'b1;
        end
    end

`ifdef HELIOS_DISPATCH_TAG_EN
    // Tag of the frame currently being returned
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   out_tag <= '0;
        else if (pop) out_tag <= fifo_head[7:0];
    end
`endif

endmodule
